// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/handshake bundle for seq_shift_add_multiplier.
// SEQ_MULT_SIGNED_EN adds the is_signed operand qualifier.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
) ();
  logic                                 start;
  logic [WIDTH-1:0]                     a;
  logic [WIDTH-1:0]                     b;
`ifdef SEQ_MULT_SIGNED_EN
  logic                                 is_signed;
`endif
  logic                                 busy;
  logic                                 done;
  logic [mult_pkg::prod_w(WIDTH)-1:0]   product;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output start, a, b, is_signed, input busy, done, product);
  modport slave  (input start, a, b, is_signed, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_shift_add_multiplier_step.sv
// One shift-add iteration: conditional add into the upper half, then shift
// {carry, upper, lower} right by one so the adder carry is never lost.
module mult_shift_add_step #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               lsb,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (lsb ? {1'b0, mcand} : '0);
    acc_nxt = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
  end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one shift-add iteration per clock.
// SEQ_MULT_SIGNED_EN enables two's-complement operands via bus.is_signed.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int PW    = prod_w(WIDTH)
) (
  input logic                      clk,
  input logic                      rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, op_a, op_b;
  logic [PW-1:0]      acc, acc_step, product_q, result;
  logic [CNT_W-1:0]   count;
  logic               last;
`ifdef SEQ_MULT_SIGNED_EN
  logic               neg, neg_nxt;
`endif

  assign last = (count == CNT_W'(WIDTH - 1));

  mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .lsb     (acc[0]),
    .acc_nxt (acc_step)
  );

  // The core only ever sees magnitudes; negating the most-negative value
  // wraps to 2^(WIDTH-1), which is exactly its unsigned magnitude.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    op_a    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    op_b    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_nxt = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    result  = neg ? -acc_step : acc_step;
`else
    op_a    = bus.a;
    op_b    = bus.b;
    result  = acc_step;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      acc       <= '0;
      count     <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mcand <= op_a;
          acc   <= {{WIDTH{1'b0}}, op_b};
          count <= '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg   <= neg_nxt;
`endif
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (last) product_q <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;
endmodule
